// File: rtl/if_id_skid_stage.sv
// Elastic IF/ID pipeline register: main entry plus one skid entry, so in_ready comes
// straight from a flop and full throughput is kept under valid/ready handshaking.
module if_id_skid_stage #(
    parameter int PC_BITS  = 32,
    parameter int IR_BITS  = 32,
    parameter int EXC_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_BITS-1:0]  PC_in,
    input  logic [IR_BITS-1:0]  IR_in,
    input  logic [EXC_BITS-1:0] exc_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_BITS-1:0]  PC_out,
    output logic [IR_BITS-1:0]  IR_out,
    output logic [EXC_BITS-1:0] exc_out,
    output logic [CNT_BITS-1:0] stall_cnt
);

    logic                main_valid;
    logic [PC_BITS-1:0]  main_pc;
    logic [IR_BITS-1:0]  main_ir;
    logic [EXC_BITS-1:0] main_exc;
    logic                skid_valid;
    logic [PC_BITS-1:0]  skid_pc;
    logic [IR_BITS-1:0]  skid_ir;
    logic [EXC_BITS-1:0] skid_exc;
    logic [CNT_BITS-1:0] stall_cnt_q;
    logic                acc;
    logic                fire;

    // skid_valid is a flop, so ready never sees out_ready combinationally
    assign in_ready  = ~skid_valid;
    assign acc       = in_valid & ~skid_valid;
    assign fire      = main_valid & out_ready;

    assign out_valid = main_valid;
    assign PC_out    = main_pc;
    assign IR_out    = main_ir;
    assign exc_out   = main_exc;
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (main_valid && !out_ready && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + CNT_BITS'(1);
        end
    end

    // Emptied entries always carry zero fields, so a bubble decodes as a NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_pc    <= '0;
            main_ir    <= '0;
            main_exc   <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_ir    <= '0;
            skid_exc   <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_pc    <= '0;
            main_ir    <= '0;
            main_exc   <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_ir    <= '0;
            skid_exc   <= '0;
        end else if (skid_valid) begin
            if (fire) begin
                main_valid <= 1'b1;
                main_pc    <= skid_pc;
                main_ir    <= skid_ir;
                main_exc   <= skid_exc;
                skid_valid <= 1'b0;
                skid_pc    <= '0;
                skid_ir    <= '0;
                skid_exc   <= '0;
            end
        end else if (acc && (!main_valid || fire)) begin
            main_valid <= 1'b1;
            main_pc    <= PC_in;
            main_ir    <= IR_in;
            main_exc   <= exc_in;
        end else if (acc) begin
            skid_valid <= 1'b1;
            skid_pc    <= PC_in;
            skid_ir    <= IR_in;
            skid_exc   <= exc_in;
        end else if (fire) begin
            main_valid <= 1'b0;
            main_pc    <= '0;
            main_ir    <= '0;
            main_exc   <= '0;
        end
    end

    a_skid_needs_main: assert property (@(posedge clk) disable iff (!rst_n)
        skid_valid |-> main_valid);
    a_bubble_is_zero: assert property (@(posedge clk) disable iff (!rst_n)
        !main_valid |-> (main_pc == '0 && main_ir == '0 && main_exc == '0));

endmodule
